// File: rtl/reg_bus_master.sv
// Initiator for the 12-bit address / 32-bit data register bus: turns one local
// command into a write (setup / byte-lane strobe / hold) or a read (setup / wait / sample).
module reg_bus_master #(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int RD_WAIT_CYC = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdWrite,
    input  logic [11:0] cmdAddr,
    input  logic [31:0] cmdData,
    input  logic [3:0]  cmdBe,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspData,
    output logic        busy,
    output logic [11:0] addr,
    output logic [31:0] dataOut,
    input  logic [31:0] dataIn,
    output logic        cs,
    output logic        wr0,
    output logic        wr1,
    output logic        wr2,
    output logic        wr3
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RDWAIT_LD = 4'(RD_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RDWAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_cnt_done;

    logic        r_write;
    logic [3:0]  r_be;
    logic [11:0] r_addr;
    logic [31:0] r_data_out;
    logic        r_cs;
    logic [3:0]  r_wr;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic        w_accept;
    logic        w_capture;
    logic        w_cs_next;
    logic [3:0]  w_wr_next;

    assign w_cnt_done = (r_cnt == 4'd0);
    assign w_accept   = (r_state == ST_IDLE) && cmdValid;
    assign w_capture  = (r_state == ST_RDWAIT) && w_cnt_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state; the counter reloads with the new state's length on every transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (cmdValid)   w_state_next = ST_SETUP;
            ST_SETUP:  if (w_cnt_done) w_state_next = r_write ? ST_STROBE : ST_RDWAIT;
            ST_STROBE: if (w_cnt_done) w_state_next = ST_HOLD;
            ST_HOLD:   if (w_cnt_done) w_state_next = ST_IDLE;
            ST_RDWAIT: if (w_cnt_done) w_state_next = ST_RESP;
            ST_RESP:   if (rspReady)   w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase

        w_cnt_next = r_cnt;
        if (w_state_next != r_state) begin
            case (w_state_next)
                ST_SETUP:  w_cnt_next = SETUP_LD;
                ST_STROBE: w_cnt_next = STROBE_LD;
                ST_HOLD:   w_cnt_next = HOLD_LD;
                ST_RDWAIT: w_cnt_next = RDWAIT_LD;
                default:   w_cnt_next = 4'd0;
            endcase
        end else if (!w_cnt_done) begin
            w_cnt_next = r_cnt - 4'd1;
        end
    end

    // Bus outputs are decoded from the upcoming state so the flops line up with it
    always_comb begin
        w_cs_next = (w_state_next == ST_SETUP)  || (w_state_next == ST_STROBE) ||
                    (w_state_next == ST_HOLD)   || (w_state_next == ST_RDWAIT);
        w_wr_next = (w_state_next == ST_STROBE) ? r_be : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_be        <= 4'b0000;
            r_addr      <= 12'd0;
            r_data_out  <= 32'd0;
            r_cs        <= 1'b0;
            r_wr        <= 4'b0000;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
        end else begin
            r_cs        <= w_cs_next;
            r_wr        <= w_wr_next;
            r_rsp_valid <= (w_state_next == ST_RESP);
            if (w_accept) begin
                r_addr  <= cmdAddr;
                r_write <= cmdWrite;
                r_be    <= cmdBe;
                if (cmdWrite) begin
                    r_data_out <= cmdData;
                end
            end
            if (w_capture) begin
                r_rsp_data <= dataIn;
            end
        end
    end

    assign cmdReady = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign rspValid = r_rsp_valid;
    assign rspData  = r_rsp_data;
    assign addr     = r_addr;
    assign dataOut  = r_data_out;
    assign cs       = r_cs;
    assign wr0      = r_wr[0];
    assign wr1      = r_wr[1];
    assign wr2      = r_wr[2];
    assign wr3      = r_wr[3];

endmodule
